// File: rtl/arb_pkg.sv
// Shared constants and types for the 8-way round-robin arbiter.
package arb_pkg;

    localparam int ARB_N        = 8;
    localparam int ARB_IDX_W    = 3;
    localparam int MAX_HOLD_DEF = 16;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter_8_if.sv
// Requester-bank <-> arbiter handshake bundle.
interface rr_arbiter_8_if;

    logic [arb_pkg::ARB_N-1:0]     req;
    logic                          done;
    logic [arb_pkg::ARB_N-1:0]     gnt;
    logic [arb_pkg::ARB_IDX_W-1:0] gnt_idx;
    logic                          gnt_valid;
    logic                          timeout;

    // Requester side: raises requests, reports completion, observes grants.
    modport master (
        output req,
        output done,
        input  gnt,
        input  gnt_idx,
        input  gnt_valid,
        input  timeout
    );

    // Arbiter side.
    modport slave (
        input  req,
        input  done,
        output gnt,
        output gnt_idx,
        output gnt_valid,
        output timeout
    );

endinterface

// File: rtl/priority_encoder_8.sv
// Lowest-set-bit encoder over an 8-bit vector; purely combinational.
module priority_encoder_8 (
    input  logic [7:0] data,
    output logic [2:0] out,
    output logic       any
);

    // Scan from the top so the lowest set bit is the last one written.
    always_comb begin
        out = 3'd0;
        any = |data;
        for (int i = 7; i >= 0; i--) begin
            if (data[i]) out = i[2:0];
        end
    end

endmodule

// File: rtl/rr_arbiter_8.sv
// 8-requester round-robin arbiter with completion/drop/hold-budget release.
// Grants are registered; at least one IDLE cycle separates consecutive grants.
module rr_arbiter_8
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic           clk,
    input  logic           rst,
    rr_arbiter_8_if.slave  bus
);

    localparam int                CNT_W    = $clog2(MAX_HOLD);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(MAX_HOLD - 1);

    arb_state_e             state, state_nxt;
    logic [ARB_IDX_W-1:0]   ptr;
    logic [CNT_W-1:0]       cnt;
    logic [ARB_N-1:0]       gnt_q;
    logic [ARB_IDX_W-1:0]   gnt_idx_q;
    logic                   gnt_valid_q;
    logic                   timeout_q;

    logic [ARB_N-1:0]       mask;
    logic [ARB_N-1:0]       masked;
    logic [ARB_IDX_W-1:0]   m_idx, u_idx, win_idx;
    logic                   m_any, u_any;
    logic                   owner_req;
    logic                   rel_to;
    logic                   grant_go;
    logic                   release_go;

    // Pass 1 only sees requesters at or above the pointer; pass 2 wraps.
    assign mask   = ~((8'd1 << ptr) - 8'd1);
    assign masked = bus.req & mask;

    priority_encoder_8 u_pe_masked (
        .data (masked),
        .out  (m_idx),
        .any  (m_any)
    );

    priority_encoder_8 u_pe_unmasked (
        .data (bus.req),
        .out  (u_idx),
        .any  (u_any)
    );

    assign win_idx   = m_any ? m_idx : u_idx;
    assign owner_req = bus.req[gnt_idx_q];
    // Budget expiry only counts as a timeout when no normal release coincides.
    assign rel_to    = (cnt == CNT_LAST) && !bus.done && owner_req;

    // Next-state and grant/release strobes.
    always_comb begin
        state_nxt  = state;
        grant_go   = 1'b0;
        release_go = 1'b0;
        case (state)
            IDLE: begin
                if (u_any) begin
                    state_nxt = BUSY;
                    grant_go  = 1'b1;
                end
            end
            BUSY: begin
                if (bus.done || !owner_req || rel_to) begin
                    state_nxt  = IDLE;
                    release_go = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Grant outputs, rotation pointer, hold counter and timeout pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_q       <= '0;
            gnt_idx_q   <= '0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
            ptr         <= '0;
            cnt         <= '0;
        end else begin
            timeout_q <= 1'b0;
            if (grant_go) begin
                gnt_q       <= 8'd1 << win_idx;
                gnt_idx_q   <= win_idx;
                gnt_valid_q <= 1'b1;
                cnt         <= '0;
            end else if (release_go) begin
                // gnt_idx keeps its last value; the pointer moves past the owner.
                gnt_q       <= '0;
                gnt_valid_q <= 1'b0;
                ptr         <= gnt_idx_q + 3'd1;
                timeout_q   <= rel_to;
            end else if (state == BUSY) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_idx   = gnt_idx_q;
    assign bus.gnt_valid = gnt_valid_q;
    assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Directed bench for rr_arbiter_8 with a 4-cycle hold budget.
module tb_rr_arbiter_8;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    rr_arbiter_8_if bus ();

    rr_arbiter_8 #(.MAX_HOLD(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.req = '0; bus.done = 1'b0;
        tick(); tick();
        checks++;
        if ({bus.gnt, bus.gnt_idx, bus.gnt_valid, bus.timeout} !== 13'd0) begin
            errors++;
            $display("FAIL reset_outputs: got gnt=%b idx=%0d v=%b to=%b, want all 0",
                     bus.gnt, bus.gnt_idx, bus.gnt_valid, bus.timeout);
        end
        checks++;
        if (dut.ptr !== 3'd0) begin
            errors++; $display("FAIL reset_ptr: got %0d want 0", dut.ptr);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (bus.gnt !== 8'd0) begin
            errors++; $display("FAIL reset_idle: got gnt=%b want 0", bus.gnt);
        end
    endtask

    task automatic test_single();
        bus.req = 8'b0000_0100;
        tick();
        checks++;
        if (bus.gnt !== 8'b0000_0100 || bus.gnt_idx !== 3'd2 || bus.gnt_valid !== 1'b1) begin
            errors++;
            $display("FAIL single_grant: got gnt=%b idx=%0d v=%b want 00000100/2/1",
                     bus.gnt, bus.gnt_idx, bus.gnt_valid);
        end
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0; bus.req = '0;
        checks++;
        if (bus.gnt !== 8'd0 || bus.gnt_valid !== 1'b0 || bus.gnt_idx !== 3'd2 || bus.timeout !== 1'b0) begin
            errors++;
            $display("FAIL single_release: got gnt=%b v=%b idx=%0d to=%b want 0/0/2/0",
                     bus.gnt, bus.gnt_valid, bus.gnt_idx, bus.timeout);
        end
        checks++;
        if (dut.ptr !== 3'd3) begin
            errors++; $display("FAIL single_ptr: got %0d want 3", dut.ptr);
        end
        tick();
    endtask

    task automatic test_rotation();
        logic [7:0] exp_gnt;
        rst = 1'b1; #2; rst = 1'b0;
        bus.req = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            exp_gnt = 8'd1 << (k % 8);
            tick();
            checks++;
            if (bus.gnt !== exp_gnt || bus.gnt_idx !== 3'(k % 8)) begin
                errors++;
                $display("FAIL rotation_grant[%0d]: got gnt=%b idx=%0d want %b/%0d",
                         k, bus.gnt, bus.gnt_idx, exp_gnt, k % 8);
            end
            bus.done = 1'b1;
            tick();
            bus.done = 1'b0;
            checks++;
            if (bus.gnt !== 8'd0 || bus.gnt_valid !== 1'b0) begin
                errors++;
                $display("FAIL rotation_idle[%0d]: got gnt=%b v=%b want 0/0",
                         k, bus.gnt, bus.gnt_valid);
            end
        end
        bus.req = '0;
        tick();
    endtask

    task automatic test_wrap_skip();
        // ptr is 1 here; grant 5 and release it so ptr becomes 6.
        bus.req = 8'b0010_0000;
        tick();
        bus.done = 1'b1; tick(); bus.done = 1'b0;
        checks++;
        if (dut.ptr !== 3'd6) begin
            errors++; $display("FAIL wrap_setup_ptr: got %0d want 6", dut.ptr);
        end
        bus.req = 8'b0010_0001;
        tick();
        checks++;
        if (bus.gnt !== 8'b0000_0001 || bus.gnt_idx !== 3'd0) begin
            errors++;
            $display("FAIL wrap_grant: got gnt=%b idx=%0d want 00000001/0", bus.gnt, bus.gnt_idx);
        end
        bus.done = 1'b1; tick(); bus.done = 1'b0;
        tick();
        checks++;
        if (bus.gnt !== 8'b0010_0000 || bus.gnt_idx !== 3'd5) begin
            errors++;
            $display("FAIL skip_grant: got gnt=%b idx=%0d want 00100000/5", bus.gnt, bus.gnt_idx);
        end
        bus.done = 1'b1; tick(); bus.done = 1'b0;
        bus.req = '0;
        tick();
    endtask

    task automatic test_timeout();
        bus.req = 8'b0000_1000;
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++;
            if (bus.gnt !== 8'b0000_1000 || bus.timeout !== 1'b0) begin
                errors++;
                $display("FAIL timeout_hold[%0d]: got gnt=%b to=%b want 00001000/0", c, bus.gnt, bus.timeout);
            end
        end
        tick();
        checks++;
        if (bus.gnt !== 8'd0 || bus.timeout !== 1'b1 || bus.gnt_valid !== 1'b0) begin
            errors++;
            $display("FAIL timeout_pulse: got gnt=%b to=%b v=%b want 0/1/0", bus.gnt, bus.timeout, bus.gnt_valid);
        end
        checks++;
        if (dut.ptr !== 3'd4) begin
            errors++; $display("FAIL timeout_ptr: got %0d want 4", dut.ptr);
        end
        tick();
        checks++;
        if (bus.gnt !== 8'b0000_1000 || bus.timeout !== 1'b0) begin
            errors++;
            $display("FAIL timeout_regrant: got gnt=%b to=%b want 00001000/0", bus.gnt, bus.timeout);
        end
    endtask

    task automatic test_done_at_limit();
        // Continues from the re-grant above (counter at 0).
        tick(); tick(); tick();
        checks++;
        if (bus.gnt !== 8'b0000_1000) begin
            errors++; $display("FAIL limit_still_held: got gnt=%b want 00001000", bus.gnt);
        end
        bus.done = 1'b1;
        tick();
        bus.done = 1'b0; bus.req = '0;
        checks++;
        if (bus.gnt !== 8'd0 || bus.timeout !== 1'b0) begin
            errors++;
            $display("FAIL limit_done_release: got gnt=%b to=%b want 0/0", bus.gnt, bus.timeout);
        end
        tick();
    endtask

    task automatic test_owner_drop();
        bus.req = 8'b0000_0110;
        tick();
        checks++;
        if (bus.gnt !== 8'b0000_0010) begin
            errors++; $display("FAIL drop_grant: got gnt=%b want 00000010", bus.gnt);
        end
        bus.req = 8'b1000_0100;
        tick();
        checks++;
        if (bus.gnt !== 8'd0 || bus.timeout !== 1'b0 || bus.gnt_idx !== 3'd1) begin
            errors++;
            $display("FAIL drop_release: got gnt=%b to=%b idx=%0d want 0/0/1", bus.gnt, bus.timeout, bus.gnt_idx);
        end
        tick();
        checks++;
        if (bus.gnt !== 8'b0000_0100) begin
            errors++; $display("FAIL drop_next: got gnt=%b want 00000100", bus.gnt);
        end
        bus.req = '0;
        tick(); tick();
    endtask

    task automatic test_async_reset();
        bus.req = 8'b1000_0000;
        tick();
        checks++;
        if (bus.gnt !== 8'b1000_0000) begin
            errors++; $display("FAIL areset_setup: got gnt=%b want 10000000", bus.gnt);
        end
        #2; rst = 1'b1; #1;
        checks++;
        if ({bus.gnt, bus.gnt_idx, bus.gnt_valid, bus.timeout} !== 13'd0 || dut.ptr !== 3'd0) begin
            errors++;
            $display("FAIL areset_immediate: got gnt=%b idx=%0d v=%b to=%b ptr=%0d want all 0",
                     bus.gnt, bus.gnt_idx, bus.gnt_valid, bus.timeout, dut.ptr);
        end
        bus.req = 8'hFF;
        #2; rst = 1'b0;
        tick();
        checks++;
        if (bus.gnt !== 8'b0000_0001 || bus.gnt_idx !== 3'd0) begin
            errors++;
            $display("FAIL areset_first: got gnt=%b idx=%0d want 00000001/0", bus.gnt, bus.gnt_idx);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_rotation();
        test_wrap_skip();
        test_timeout();
        test_done_at_limit();
        test_owner_drop();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Bound on total run time.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within 100000 time units");
        $fatal(1);
    end

endmodule

// File: doc/rr_arbiter_8.md
# rr_arbiter_8

Round-robin arbiter that shares one downstream resource among 8 requesters. It uses two priority-encoder passes over the request vector, one masked and one unmasked, to pick a winner. It holds the grant until the owner signals completion, drops its request, or exceeds a hold-time budget. It sits between the requester bank and the shared datapath, and drives both a one-hot grant and a binary grant index.

## Interface
- `N`, 8: number of requesters; only 8 is supported.
- `MAX_HOLD`, 16: maximum grant length in cycles; legal range 2..255.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req` in 8: request vector; bit i is held high by requester i while it wants or uses the resource.
- `done` in 1: single-cycle pulse from the current owner marking completion; ignored in IDLE.
- `gnt` out 8: one-hot grant, registered.
- `gnt_idx` out 3: binary index of the granted requester, registered; valid only when `gnt_valid`=1.
- `gnt_valid` out 1: high while any grant is active; equals OR of `gnt`.
- `timeout` out 1: single-cycle pulse when a grant is revoked by the hold budget.

## Operation
- Reset values: `gnt`=0, `gnt_idx`=0, `gnt_valid`=0, `timeout`=0, state=IDLE, rotation pointer `ptr`=0, hold counter=0.
- FSM has two states: IDLE and BUSY.
- **IDLE to BUSY:** taken when `req`≠0.
  - Winner search pass 1: `masked = req & ~((1<<ptr)-1)`. If `masked`≠0, the winner is its lowest set bit.
  - Pass 2: otherwise, the winner is the lowest set bit of `req`.
  - On the transition, load `gnt`, `gnt_idx` and `gnt_valid`, and clear the hold counter.
- **BUSY:** the hold counter increments every cycle. The grant is released when any of the following holds:
  - (a) `done`=1;
  - (b) `req[gnt_idx]`=0;
  - (c) the counter equals `MAX_HOLD-1` and neither (a) nor (b) holds. This case also asserts `timeout` in the cycle after the releasing edge, aligned with `gnt` falling.
- **On release:** go to IDLE, clear `gnt` and `gnt_valid`, and set `ptr = (gnt_idx+1) mod 8` (wraps from 7 to 0). `gnt_idx` holds its last value.
- IDLE is always occupied for at least one cycle between grants. This guarantees a dead cycle so the resource can be re-steered.
- `done` together with the counter reaching its limit counts as a normal release; no `timeout`.
- Requests that appear or drop while BUSY have no effect except the owner's own drop, case (b).
- A requester that was timed out and keeps `req` high is treated like any other requester. `ptr` has already moved past it, so it waits a full rotation.

## Timing
- **Grant latency:** `req` sampled high at edge t gives `gnt` high after edge t. There is no combinational path from `req` to `gnt`.
- **Release latency:** a release condition sampled at edge k gives `gnt` low after edge k. The earliest next grant is at edge k+1.
- Maximum grant length is `MAX_HOLD` cycles. Every requester holding `req` high is granted within 7×(`MAX_HOLD`+1) cycles of raising it.
- Hold counter width is clog2(`MAX_HOLD`). It never wraps, because it is cleared on every grant.
- **Reset mid-grant:** all outputs drop to their reset values immediately (asynchronously), and `ptr` returns to 0.

## Structure
- Shared package `arb_pkg`:
  - `ARB_N`=8 and `ARB_IDX_W`=3;
  - state enum `{IDLE, BUSY}`;
  - the default `MAX_HOLD`.
- One sub-module, `priority_encoder_8`: combinational, `data[7:0]` in, `out[2:0]` (index of the lowest set bit) and `any` out.
  - Instantiated twice, once for the masked vector and once for the unmasked vector.
- The top level contains the FSM, `ptr`, the hold counter and the output registers.

## Test plan
- **Reset and single request:** reset, then `req`=8'b0000_0100. Expect `gnt`=8'b0000_0100, `gnt_idx`=2 and `gnt_valid`=1 one edge later. Pulse `done`; expect `gnt`=0 one edge later and `ptr`=3.
- **Rotation:** hold `req`=8'hFF and pulse `done` one cycle after every grant. Expect grant order 0,1,…,7,0 with exactly one IDLE cycle between grants.
- **Pointer wrap and skip:** with `ptr`=6 and `req`=8'b0010_0001, expect index 0 to be granted (the masked vector is empty, so the search wraps). Then `ptr`=1 and index 5 is granted next.
- **Timeout:** `MAX_HOLD`=4 and `req`=8'b0000_1000 held with no `done`. Expect `gnt` high for exactly 4 cycles, then `timeout`=1 for one cycle with `gnt`=0, then a re-grant to 3 after one IDLE cycle.
- **Simultaneous done and timeout:** `done` asserted in the counter's final cycle. Expect a release with `timeout` kept at 0.
- **Async reset mid-grant:** assert `rst` between edges while `gnt`=8'b1000_0000. Expect all outputs 0 before the next edge. After reset is deasserted with `req`=8'hFF, the first grant goes to 0.
